// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM states, flag indices and flag masking for the ALU command driver
package alu_pkg;

    localparam logic [2:0] OP_ADDU = 3'b000;
    localparam logic [2:0] OP_ADDS = 3'b001;
    localparam logic [2:0] OP_SUBU = 3'b010;
    localparam logic [2:0] OP_SUBS = 3'b011;

    localparam int FLG_CARRY = 2;
    localparam int FLG_OVF   = 1;
    localparam int FLG_ZERO  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } drv_state_e;

    // True for opcodes 0xx; opcodes 1xx receive an error response.
    function automatic logic op_supported(input logic op_msb);
        return !op_msb;
    endfunction

    // Signed ops (opcode bit 0 set) report overflow only; unsigned ops report carry only.
    function automatic logic [2:0] mask_flags(input logic is_signed, input logic carry,
                                              input logic ovf, input logic zero);
        logic [2:0] f;
        f            = 3'b000;
        f[FLG_CARRY] = carry & ~is_signed;
        f[FLG_OVF]   = ovf & is_signed;
        f[FLG_ZERO]  = zero;
        return f;
    endfunction

endpackage

// File: rtl/alu_cmd_driver_if.sv
// rtl/alu_cmd_driver_if.sv - command, ALU and response signal bundle; cmd_chain exists only with ALU_DRV_CHAIN_EN
interface alu_cmd_driver_if #(
    parameter int NUMBITS  = 16,
    parameter int CNT_BITS = 8
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [2:0]          cmd_opcode;
    logic [NUMBITS-1:0]  cmd_a;
    logic [NUMBITS-1:0]  cmd_b;
`ifdef ALU_DRV_CHAIN_EN
    logic                cmd_chain;
`endif
    logic [NUMBITS-1:0]  alu_a;
    logic [NUMBITS-1:0]  alu_b;
    logic [2:0]          alu_opcode;
    logic [NUMBITS-1:0]  alu_result;
    logic                alu_carryout;
    logic                alu_overflow;
    logic                alu_zero;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [NUMBITS-1:0]  rsp_result;
    logic [2:0]          rsp_flags;
    logic                rsp_err;
    logic [CNT_BITS-1:0] ovf_count;

    // Control master plus ALU: issues commands, evaluates operands, consumes responses.
    modport master (
`ifdef ALU_DRV_CHAIN_EN
        output cmd_chain,
`endif
        output cmd_valid, cmd_opcode, cmd_a, cmd_b,
        input  cmd_ready,
        input  alu_a, alu_b, alu_opcode,
        output alu_result, alu_carryout, alu_overflow, alu_zero,
        input  rsp_valid, rsp_result, rsp_flags, rsp_err, ovf_count,
        output rsp_ready
    );

    // The driver itself.
    modport slave (
`ifdef ALU_DRV_CHAIN_EN
        input  cmd_chain,
`endif
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b,
        output cmd_ready,
        output alu_a, alu_b, alu_opcode,
        input  alu_result, alu_carryout, alu_overflow, alu_zero,
        output rsp_valid, rsp_result, rsp_flags, rsp_err, ovf_count,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_sat_counter.sv
// rtl/alu_sat_counter.sv - saturating up-counter with increment enable
module alu_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q, count_d;

    // Next count: step on inc, stick at all-ones.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/alu_cmd_driver.sv
// rtl/alu_cmd_driver.sv - ALU command driver: accept, drive operands, settle, capture, respond (ALU_DRV_CHAIN_EN adds result chaining)
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int NUMBITS       = 16,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_BITS      = 8
) (
    input  logic              clk,
    input  logic              reset,
    alu_cmd_driver_if.slave   bus
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    drv_state_e         state_q, state_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [NUMBITS-1:0] alu_a_q, alu_a_d;
    logic [NUMBITS-1:0] alu_b_q, alu_b_d;
    logic [2:0]         alu_opcode_q, alu_opcode_d;
    logic [NUMBITS-1:0] rsp_result_q, rsp_result_d;
    logic [2:0]         rsp_flags_q, rsp_flags_d;
    logic               rsp_err_q, rsp_err_d;
    logic [SW-1:0]      settle_q, settle_d;
    logic [2:0]         cap_flags;
    logic               ovf_inc;
`ifdef ALU_DRV_CHAIN_EN
    logic [NUMBITS-1:0] chain_q, chain_d;
`endif

    // Flags as they will be reported if captured this cycle.
    always_comb begin
        cap_flags = mask_flags(alu_opcode_q[0], bus.alu_carryout, bus.alu_overflow, bus.alu_zero);
    end

    // Next-state and next-output logic for the IDLE -> DRIVE -> RESP sequence.
    always_comb begin
        state_d      = state_q;
        cmd_ready_d  = cmd_ready_q;
        rsp_valid_d  = rsp_valid_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_opcode_d = alu_opcode_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        settle_d     = settle_q;
        ovf_inc      = 1'b0;
`ifdef ALU_DRV_CHAIN_EN
        chain_d      = chain_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (op_supported(bus.cmd_opcode[2])) begin
                        alu_a_d = bus.cmd_a;
`ifdef ALU_DRV_CHAIN_EN
                        if (bus.cmd_chain) begin
                            alu_a_d = chain_q;
                        end
`endif
                        alu_b_d      = bus.cmd_b;
                        alu_opcode_d = bus.cmd_opcode;
                        settle_d     = '0;
                        state_d      = ST_DRIVE;
                    end else begin
                        // Unsupported: answer immediately, leave the ALU operands alone.
                        rsp_err_d    = 1'b1;
                        rsp_result_d = '0;
                        rsp_flags_d  = 3'b000;
                        rsp_valid_d  = 1'b1;
                        state_d      = ST_RESP;
                    end
                end
            end
            ST_DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    rsp_result_d = bus.alu_result;
                    rsp_flags_d  = cap_flags;
                    rsp_err_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    settle_d     = '0;
                    ovf_inc      = cap_flags[FLG_OVF];
                    state_d      = ST_RESP;
`ifdef ALU_DRV_CHAIN_EN
                    chain_d      = bus.alu_result;
`endif
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opcode_q <= 3'b000;
            rsp_result_q <= '0;
            rsp_flags_q  <= 3'b000;
            rsp_err_q    <= 1'b0;
            settle_q     <= '0;
`ifdef ALU_DRV_CHAIN_EN
            chain_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_opcode_q <= alu_opcode_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
            settle_q     <= settle_d;
`ifdef ALU_DRV_CHAIN_EN
            chain_q      <= chain_d;
`endif
        end
    end

    alu_sat_counter #(
        .WIDTH (CNT_BITS)
    ) u_ovf_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (ovf_inc),
        .count (bus.ovf_count)
    );

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_opcode = alu_opcode_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;
    assign bus.rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb/tb_alu_cmd_driver.sv - self-checking bench for alu_cmd_driver (ALU_DRV_CHAIN_EN adds the chaining step)
module tb_alu_cmd_driver;
    localparam int NB     = 16;
    localparam int SETTLE = 1;
    localparam int CNTB   = 8;

    logic clk;
    logic reset;

    alu_cmd_driver_if #(.NUMBITS(NB), .CNT_BITS(CNTB)) bus ();

    alu_cmd_driver #(
        .NUMBITS       (NB),
        .SETTLE_CYCLES (SETTLE),
        .CNT_BITS      (CNTB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU attached to the driver outputs; carry on subtract means borrow.
    always_comb begin
        logic [NB:0] s;
        s = '0;
        bus.alu_result   = '0;
        bus.alu_carryout = 1'b0;
        bus.alu_overflow = 1'b0;
        case (bus.alu_opcode)
            3'b000, 3'b001: begin
                s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                bus.alu_result   = s[NB-1:0];
                bus.alu_carryout = s[NB];
                bus.alu_overflow = (bus.alu_a[NB-1] == bus.alu_b[NB-1]) && (s[NB-1] != bus.alu_a[NB-1]);
            end
            3'b010, 3'b011: begin
                s = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
                bus.alu_result   = s[NB-1:0];
                bus.alu_carryout = s[NB];
                bus.alu_overflow = (bus.alu_a[NB-1] != bus.alu_b[NB-1]) && (s[NB-1] != bus.alu_a[NB-1]);
            end
            default: ;
        endcase
        bus.alu_zero = (bus.alu_result == '0);
    end

    int vectors;
    int miscompares;

    // Reference state.
    int           m_ovf;
    logic [15:0]  m_last_res;
    logic [15:0]  m_alu_a, m_alu_b;
    logic [2:0]   m_alu_op;

    // Last response as observed on the bus.
    logic [15:0]  obs_res;
    logic [2:0]   obs_flg;
    logic         obs_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Specification-level model of one operation.
    task automatic ref_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] res, output logic [2:0] flg, output logic err);
        int ua, ub, sa, sb, v;
        logic carry, ovf;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        carry = 1'b0;
        ovf   = 1'b0;
        err   = 1'b0;
        v     = 0;
        case (op)
            3'b000: begin v = ua + ub; carry = (v > 65535); end
            3'b001: begin v = sa + sb; ovf = (v > 32767) || (v < -32768); end
            3'b010: begin v = ua - ub; carry = (ua < ub); end
            3'b011: begin v = sa - sb; ovf = (v > 32767) || (v < -32768); end
            default: err = 1'b1;
        endcase
        res = err ? 16'h0000 : v[15:0];
        flg = err ? 3'b000 : {carry, ovf, (res == 16'h0000)};
    endtask

    task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic chain, input int hold);
        logic [15:0] a_eff, e_res;
        logic [2:0]  e_flg;
        logic        e_err;
        int          cyc;
        a_eff = a;
`ifdef ALU_DRV_CHAIN_EN
        if (chain) a_eff = m_last_res;
`else
        if (chain) a_eff = a;
`endif
        ref_op(op, a_eff, b, e_res, e_flg, e_err);

        cyc = 0;
        while (!bus.cmd_ready && cyc < 50) begin @(posedge clk); #1; cyc++; end
        chk("cmd_ready_before_accept", bus.cmd_ready, 1'b1);

        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = op;
        bus.cmd_a      = a;
        bus.cmd_b      = b;
`ifdef ALU_DRV_CHAIN_EN
        bus.cmd_chain  = chain;
`endif
        @(posedge clk); #1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_opcode = 3'($urandom);
        bus.cmd_a      = 16'($urandom);
        bus.cmd_b      = 16'($urandom);
        chk("cmd_ready_busy", bus.cmd_ready, 1'b0);

        cyc = 0;
        while (!bus.rsp_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        chk("rsp_latency", 64'(cyc), e_err ? 64'd0 : 64'(SETTLE));

        if (!e_err) begin
            m_alu_a    = a_eff;
            m_alu_b    = b;
            m_alu_op   = op;
            m_last_res = e_res;
            if (e_flg[1] && m_ovf < 255) m_ovf++;
        end
        chk("rsp_result", bus.rsp_result, e_res);
        chk("rsp_flags",  bus.rsp_flags,  e_flg);
        chk("rsp_err",    bus.rsp_err,    e_err);
        chk("alu_a",      bus.alu_a,      m_alu_a);
        chk("alu_b",      bus.alu_b,      m_alu_b);
        chk("alu_opcode", bus.alu_opcode, m_alu_op);
        chk("ovf_count",  bus.ovf_count,  m_ovf[7:0]);
        obs_res = bus.rsp_result;
        obs_flg = bus.rsp_flags;
        obs_err = bus.rsp_err;

        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_rsp_valid",  bus.rsp_valid,  1'b1);
            chk("hold_rsp_result", bus.rsp_result, e_res);
            chk("hold_rsp_flags",  bus.rsp_flags,  e_flg);
            chk("hold_cmd_ready",  bus.cmd_ready,  1'b0);
        end

        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_after_hs", bus.rsp_valid, 1'b0);
        chk("cmd_ready_after_hs", bus.cmd_ready, 1'b1);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_cmd_ready"},  bus.cmd_ready,  1'b1);
        chk({tag, "_rsp_valid"},  bus.rsp_valid,  1'b0);
        chk({tag, "_alu_a"},      bus.alu_a,      16'h0000);
        chk({tag, "_alu_b"},      bus.alu_b,      16'h0000);
        chk({tag, "_alu_opcode"}, bus.alu_opcode, 3'b000);
        chk({tag, "_rsp_result"}, bus.rsp_result, 16'h0000);
        chk({tag, "_rsp_flags"},  bus.rsp_flags,  3'b000);
        chk({tag, "_rsp_err"},    bus.rsp_err,    1'b0);
        chk({tag, "_ovf_count"},  bus.ovf_count,  8'h00);
    endtask

    task automatic model_reset();
        m_ovf      = 0;
        m_last_res = 16'h0000;
        m_alu_a    = 16'h0000;
        m_alu_b    = 16'h0000;
        m_alu_op   = 3'b000;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_reset();
        bus.cmd_valid  = 1'b0;
        bus.cmd_opcode = 3'b000;
        bus.cmd_a      = 16'h0000;
        bus.cmd_b      = 16'h0000;
`ifdef ALU_DRV_CHAIN_EN
        bus.cmd_chain  = 1'b0;
`endif
        bus.rsp_ready  = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        // 1: unsigned add wraps to zero, carry and zero reported
        do_op(3'b000, 16'hFFFF, 16'h0001, 1'b0, 0);
        chk("t1_result", obs_res, 16'h0000);
        chk("t1_flags",  obs_flg, 3'b101);

        // 2: signed add overflow
        do_op(3'b001, 16'h7FFF, 16'h0001, 1'b0, 0);
        chk("t2_result", obs_res, 16'h8000);
        chk("t2_flags",  obs_flg, 3'b010);
        chk("t2_ovf_count", bus.ovf_count, 8'd1);

        // 3: unsigned subtract with borrow, then exact zero
        do_op(3'b010, 16'h0003, 16'h0005, 1'b0, 0);
        chk("t3a_result", obs_res, 16'hFFFE);
        chk("t3a_carry",  obs_flg[2], 1'b1);
        do_op(3'b010, 16'h0005, 16'h0005, 1'b0, 0);
        chk("t3b_result", obs_res, 16'h0000);
        chk("t3b_flags",  obs_flg, 3'b001);

        // 4: unsupported opcode answers next cycle, ALU opcode untouched
        do_op(3'b101, 16'h1234, 16'h5678, 1'b0, 0);
        chk("t4_err",        obs_err, 1'b1);
        chk("t4_result",     obs_res, 16'h0000);
        chk("t4_alu_opcode", bus.alu_opcode, 3'b010);

        // 5: consumer stalls for five cycles
        do_op(3'b011, 16'h8000, 16'h0001, 1'b0, 5);
        chk("t5_flags", obs_flg, 3'b010);

`ifdef ALU_DRV_CHAIN_EN
        // chaining: previous result replaces A
        do_op(3'b000, 16'h0002, 16'h0003, 1'b0, 0);
        do_op(3'b000, 16'hDEAD, 16'h0001, 1'b1, 0);
        chk("chain_result", obs_res, 16'h0006);
`endif

        // random mix of opcodes, operands and stall lengths
        for (int i = 0; i < 60; i++) begin
            do_op(3'($urandom), 16'($urandom), 16'($urandom),
                  1'($urandom), int'($urandom_range(0, 3)));
        end

        // 6: reset during DRIVE abandons the operation
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = 3'b001;
        bus.cmd_a      = 16'h7FFF;
        bus.cmd_b      = 16'h7FFF;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        reset = 1'b0;
        #2;
        chk_reset_values("mid_reset");
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("post_reset_no_rsp", bus.rsp_valid, 1'b0);
        end

        // overflow counter saturates
        for (int i = 0; i < 300; i++) begin
            do_op(3'b001, 16'h7FFF, 16'($urandom_range(1, 16'h7FFF)), 1'b0, 0);
        end
        chk("ovf_saturated", bus.ovf_count, 8'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
